// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM s1 slave bus plus irq sender
// for the edge-capturing input PIO.
interface pio_in_edge_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );
endinterface

// File: rtl/pio_in_edge_irq.sv
// Input PIO with per-bit edge capture and maskable irq.
// Define PIO_IN_SYNC_EN to add a 2-flop input synchronizer.
module pio_in_edge_irq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned EDGE_TYPE = 0,
  parameter int unsigned IRQ_TYPE = 1,
  parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  pio_in_edge_irq_if.slave s1
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_word;
  logic             wr_en;
  logic             irq_src;

`ifdef PIO_IN_SYNC_EN
  logic [WIDTH-1:0] sync0;
  logic [WIDTH-1:0] sync1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= in_port;
      sync1 <= sync0;
    end
  end

  assign data_in = sync1;
`else
  assign data_in = in_port;
`endif

  // Upper write bits are don't-care for narrow ports
  if (WIDTH < 32) begin : g_narrow
    logic unused_wdata;
    assign unused_wdata = ^s1.writedata[31:WIDTH];
  end

  assign wdata = s1.writedata[WIDTH-1:0];
  assign wr_en = s1.chipselect & ~s1.write_n;

  always_comb begin
    edge_det = data_in & ~d1;
    if (EDGE_TYPE == 1)
      edge_det = ~data_in & d1;
    else if (EDGE_TYPE == 2)
      edge_det = data_in ^ d1;
  end

  assign clr = (wr_en && s1.address == 2'd3)
             ? wdata : '0;

  always_comb begin
    rd_word = '0;
    unique case (s1.address)
      2'd0: rd_word[WIDTH-1:0] = data_in;
      2'd2: rd_word[WIDTH-1:0] = irqmask;
      2'd3: rd_word[WIDTH-1:0] = edgecapture;
      default: rd_word = '0;
    endcase
  end

  assign irq_src = (IRQ_TYPE == 0)
                 ? |(data_in & irqmask)
                 : |(edgecapture & irqmask);

  // A fresh edge beats a same-cycle W1C clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1          <= '0;
      edgecapture <= '0;
      irqmask     <= RESET_MASK;
      s1.readdata <= '0;
      s1.irq      <= 1'b0;
    end else begin
      d1          <= data_in;
      edgecapture <= (edgecapture & ~clr) | edge_det;
      if (wr_en && s1.address == 2'd2)
        irqmask <= wdata;
      s1.readdata <= rd_word;
      s1.irq      <= irq_src;
    end
  end

endmodule
